// File: rtl/ras_pkg.sv
// ras_pkg: default sizes and snapshot record for the return address stack (snapshot built only with SPEC_RAS_RECOVER_EN)
package ras_pkg;
    localparam int RAS_DEPTH  = 8;
    localparam int RAS_AW     = 64;
    localparam int RAS_TP_MAX = 16;
    localparam int RAS_AW_MAX = 128;

    typedef struct packed {
        logic [RAS_TP_MAX-1:0] tp;
        logic [RAS_TP_MAX:0]   count;
        logic [RAS_AW_MAX-1:0] entry;
    } ras_snap_t;
endpackage

// File: rtl/ras_ckpt.sv
// ras_ckpt: speculative snapshot register and restore values for spec_ras (used only with SPEC_RAS_RECOVER_EN)
module ras_ckpt
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ckpt_i,
    input  logic          recover_i,
    input  logic [PW-1:0] tp_i,
    input  logic [CW-1:0] cnt_i,
    input  logic [AW-1:0] entry_i,
    output logic [PW-1:0] tp_o,
    output logic [CW-1:0] cnt_o,
    output logic [AW-1:0] entry_o
);
    ras_snap_t snap_q, snap_d;
    logic      unused_hi;

    // capture pre-update state on ckpt; a same-cycle recover wins and keeps the old snapshot
    always_comb begin
        snap_d = snap_q;
        if (ckpt_i && !recover_i)
            snap_d = '{tp: RAS_TP_MAX'(tp_i), count: (RAS_TP_MAX+1)'(cnt_i), entry: RAS_AW_MAX'(entry_i)};
    end

    // snapshot register; reset value is the empty stack
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) snap_q <= '0;
        else        snap_q <= snap_d;

    assign tp_o      = snap_q.tp[PW-1:0];
    assign cnt_o     = snap_q.count[CW-1:0];
    assign entry_o   = snap_q.entry[AW-1:0];
    assign unused_hi = ^{snap_q.tp[RAS_TP_MAX-1:PW], snap_q.count[RAS_TP_MAX:CW], snap_q.entry[RAS_AW_MAX-1:AW]};
endmodule

// File: rtl/spec_ras.sv
// spec_ras: circular return address stack with overwrite-on-full and optional checkpoint/recover (SPEC_RAS_RECOVER_EN)
module spec_ras
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ras_push_i,
    input  logic          ras_pop_i,
    input  logic [AW-1:0] ras_addr_i,
    input  logic          ras_ckpt_i,
    input  logic          ras_recover_i,
    output logic [AW-1:0] ras_addr_o,
    output logic          ras_empty_o,
    output logic          ras_full_o,
    output logic [CW-1:0] ras_count_o,
    output logic          ras_udf_o
);
    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] tp_q, tp_d, wa, rec_tp;
    logic [CW-1:0] cnt_q, cnt_d, rec_cnt;
    logic          udf_q, udf_d, we, rec, empty, full;
    logic [AW-1:0] wd, top, rec_entry;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    assign top   = empty ? '0 : mem[tp_q];

`ifdef SPEC_RAS_RECOVER_EN
    assign rec = ras_recover_i;
    ras_ckpt #(.DEPTH(DEPTH), .AW(AW)) u_ckpt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ckpt_i    (ras_ckpt_i),
        .recover_i (ras_recover_i),
        .tp_i      (tp_q),
        .cnt_i     (cnt_q),
        .entry_i   (top),
        .tp_o      (rec_tp),
        .cnt_o     (rec_cnt),
        .entry_o   (rec_entry)
    );
`else
    logic unused_ckpt;
    assign unused_ckpt = ^{ras_ckpt_i, ras_recover_i};
    assign rec         = 1'b0;
    assign rec_tp      = '0;
    assign rec_cnt     = '0;
    assign rec_entry   = '0;
`endif

    // next pointer/count and the single storage write for this cycle
    always_comb begin
        tp_d  = tp_q;
        cnt_d = cnt_q;
        udf_d = 1'b0;
        we    = 1'b0;
        wa    = tp_q;
        wd    = ras_addr_i;
        if (rec) begin
            tp_d  = rec_tp;
            cnt_d = rec_cnt;
            we    = 1'b1;
            wa    = rec_tp;
            wd    = rec_entry;
        end else if (ras_push_i && ras_pop_i && !empty) begin
            we = 1'b1;
        end else if (ras_push_i) begin
            tp_d  = tp_q + 1'b1;
            wa    = tp_q + 1'b1;
            we    = 1'b1;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
        end else if (ras_pop_i) begin
            udf_d = empty;
            tp_d  = empty ? tp_q : tp_q - 1'b1;
            cnt_d = empty ? cnt_q : cnt_q - 1'b1;
        end
    end

    // pointer, count and underflow pulse registers
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            tp_q  <= '0;
            cnt_q <= '0;
            udf_q <= 1'b0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            udf_q <= udf_d;
        end

    // storage array; unreset, writes blocked while reset is held
    always_ff @(posedge clk_i)
        if (rst_i && we) mem[wa] <= wd;

    assign ras_addr_o  = top;
    assign ras_empty_o = empty;
    assign ras_full_o  = full;
    assign ras_count_o = cnt_q;
    assign ras_udf_o   = udf_q;
endmodule

// File: doc/spec_ras.md
SPEC_RAS -- requirements
Module: spec_ras

Interface
REQ-001 Parameter DEPTH, default 8, stack entries; power of two, minimum 2.
REQ-002 Parameter AW, default 64, return-address width in bits.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 ras_push_i  input  1  push ras_addr_i (call).
REQ-006 ras_pop_i  input  1  pop top entry (return).
REQ-007 ras_addr_i  input  AW  address to push.
REQ-008 ras_ckpt_i  input  1  save speculative snapshot.
REQ-009 ras_recover_i  input  1  restore last snapshot (mispredict).
REQ-010 ras_addr_o  output  AW  current top entry, combinational from registered state.
REQ-011 ras_empty_o  output  1  count == 0.
REQ-012 ras_full_o  output  1  count == DEPTH.
REQ-013 ras_count_o  output  $clog2(DEPTH)+1  valid entries.
REQ-014 ras_udf_o  output  1  one-cycle pulse, registered: pop attempted while empty.

Function
REQ-015 Storage SHALL be a circular array of DEPTH entries with top pointer tp (index of top entry) and saturating count 0..DEPTH.
REQ-016 ras_addr_o SHALL equal mem[tp] when count > 0, else all zeros.
REQ-017 Push only: tp <= tp+1 mod DEPTH, mem[tp+1] <= ras_addr_i, count <= min(count+1, DEPTH).
REQ-018 Push when full SHALL overwrite the oldest entry; count stays DEPTH, ras_full_o stays 1.
REQ-019 Pop only, count > 0: tp <= tp-1 mod DEPTH, count <= count-1; entry contents unchanged.
REQ-020 Pop only, count == 0: tp and count unchanged; ras_udf_o = 1 next cycle.
REQ-021 Push and pop same cycle, count > 0: mem[tp] <= ras_addr_i; tp and count unchanged (replace top).
REQ-022 Push and pop same cycle, count == 0: behave as push only; no underflow pulse.
REQ-023 New top value SHALL appear on ras_addr_o the cycle after the push/pop edge (latency 1).
REQ-024 ras_ckpt_i SHALL capture {tp, count, mem[tp]} as registered at that cycle's start, before that cycle's push/pop.
REQ-025 ras_recover_i SHALL restore tp and count from the snapshot and rewrite mem[saved tp] with the saved entry, effective next cycle.
REQ-026 ras_recover_i SHALL take priority over push, pop and ckpt in the same cycle; those are ignored.
REQ-027 Recover with no snapshot since reset SHALL restore the empty state (tp=0, count=0).

Reset
REQ-028 While rst_i = 0: tp = 0, count = 0, snapshot = empty, ras_udf_o = 0; ras_empty_o = 1, ras_full_o = 0, ras_addr_o = 0.
REQ-029 Storage array contents need not be reset.
REQ-030 Reset asserted mid-operation SHALL discard in-flight push/pop/ckpt/recover immediately.

Configuration
REQ-031 Macro SPEC_RAS_RECOVER_EN: defined -> REQ-024..REQ-027 implemented.
REQ-032 Not defined -> snapshot logic absent; ras_ckpt_i and ras_recover_i ports remain present but are ignored.

Structure
REQ-033 Package ras_pkg SHALL hold default DEPTH and AW constants and the snapshot struct typedef {tp, count, entry}.
REQ-034 Snapshot register and restore mux SHALL be sub-module ras_ckpt, instantiated only under SPEC_RAS_RECOVER_EN.

Verification (DEPTH=4, AW=64)
REQ-035 Push 0x100, 0x200, 0x300, 0x400 -> count 4, full=1, addr_o=0x400; then 4 pops -> 0x300, 0x200, 0x100, empty=1, addr_o=0.
REQ-036 Push 0x100..0x500 (5 pushes) -> full=1, addr_o=0x500; 4 pops -> 0x400, 0x300, 0x200, then empty; 0x100 lost.
REQ-037 Empty stack, pop -> udf pulse for exactly 1 cycle, count stays 0; simultaneous push 0x80 + pop while empty -> count 1, addr_o=0x80, no udf.
REQ-038 Stack {0x100, 0x200}, push 0x300 + pop same cycle -> count 2, addr_o=0x300; one pop -> 0x100.
REQ-039 Stack {0x100, 0x200}, ckpt; pop; push 0x900; recover -> count 2, addr_o=0x200; ckpt+recover same cycle -> prior snapshot used.
REQ-040 Reset asserted during push at count 3 -> next cycle count 0, empty=1, addr_o=0; build without macro: recover has no effect.
